// File: rtl/f32_wrfifo_pkg.sv
// f32_wrfifo_pkg
// Shared definitions for the write-FIFO lane controller: the one-hot mux select
// encoding, the per-entry shift-distance width and the occupancy width helper.
// Used by f32_wrfifo_sel_gen and f32_wrfifo_ctrl.

package f32_wrfifo_pkg;

    // Bit index of the select equals the data-array mux port.
    typedef logic [2:0] wrfifo_sel_t;

    localparam wrfifo_sel_t SEL_LOAD  = 3'b001;
    localparam wrfifo_sel_t SEL_SHIFT = 3'b010;
    localparam wrfifo_sel_t SEL_HOLD  = 3'b100;

    // Width of each per-entry shift distance field.
    localparam int unsigned DCNT_W = 4;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned WFFOCNT_W(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/f32_wrfifo_sel_gen.sv
// f32_wrfifo_sel_gen
// Per-entry combinational steering decoder. One instance per FIFO entry.
//   idx_i      entry index
//   cnt_i      current occupancy c
//   pop_i      effective (already clamped) pop count k
//   push_acc_i push accepted this cycle
//   sel_o      one-hot mux select (LOAD / SHIFT / HOLD)
//   dcnt_o     shift distance, nonzero only with SHIFT

module f32_wrfifo_sel_gen
    import f32_wrfifo_pkg::*;
#(
    parameter int unsigned CNT_W = 5
) (
    input  logic [CNT_W-1:0]  idx_i,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic [CNT_W-1:0]  pop_i,
    input  logic              push_acc_i,
    output wrfifo_sel_t       sel_o,
    output logic [DCNT_W-1:0] dcnt_o
);

    // Entries still valid after the drain; pop_i <= cnt_i so no underflow.
    logic [CNT_W-1:0] live;
    assign live = cnt_i - pop_i;

    always_comb begin
        sel_o  = SEL_HOLD;
        dcnt_o = '0;
        if (idx_i < live) begin
            // Survivors move toward the head; nothing moves when k is 0.
            if (pop_i != '0) begin
                sel_o  = SEL_SHIFT;
                dcnt_o = DCNT_W'(pop_i);
            end
        end else if ((idx_i == live) && push_acc_i) begin
            // New tail lands just behind the last survivor.
            sel_o = SEL_LOAD;
        end
    end

endmodule

// File: rtl/f32_wrfifo_ctrl.sv
// f32_wrfifo_ctrl
// Occupancy and steering controller for one write-FIFO lane. Converts a push
// request and a drain count into per-entry selects / shift distances for the
// downstream data array, and tracks fill level and pop-underflow status.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   push_vld_i, push_dat_i   write request and data
//   push_rdy_o               push accepted this cycle (combinational)
//   pop_cnt_i                entries drained this cycle
//   wrfifo_vwrite_dat_o      push data broadcast to every entry
//   wrfifo_dcnt_o            per-entry shift distance
//   wrfifo_new_dat_sel_o     per-entry one-hot select
//   wrfifo_vld_o             per-entry valid (registered)
//   wrfifo_cnt_o             occupancy (registered)
//   pop_err_o                sticky: a pop exceeded occupancy
//   stat_hwm_o, stat_ovf_cnt_o  only with F32_WRFIFO_CTRL_STAT_EN defined:
//                            occupancy high-water mark and saturating count of
//                            cycles with a refused push.

module f32_wrfifo_ctrl
    import f32_wrfifo_pkg::*;
#(
    parameter  int unsigned WIDTH   = 256,
    parameter  int unsigned WFFOCNT = 16,
    parameter  int unsigned MAXPOP  = 2,
    localparam int unsigned CntW    = WFFOCNT_W(WFFOCNT)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        push_vld_i,
    input  logic [WIDTH-1:0]            push_dat_i,
    output logic                        push_rdy_o,
    input  logic [1:0]                  pop_cnt_i,
    output logic [WIDTH*WFFOCNT-1:0]    wrfifo_vwrite_dat_o,
    output logic [DCNT_W*WFFOCNT-1:0]   wrfifo_dcnt_o,
    output logic [3*WFFOCNT-1:0]        wrfifo_new_dat_sel_o,
    output logic [WFFOCNT-1:0]          wrfifo_vld_o,
    output logic [CntW-1:0]             wrfifo_cnt_o,
`ifdef F32_WRFIFO_CTRL_STAT_EN
    output logic [CntW-1:0]             stat_hwm_o,
    output logic [15:0]                 stat_ovf_cnt_o,
`endif
    output logic                        pop_err_o
);

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WFFOCNT-1:0] vld_q, vld_d;
    logic               pop_err_q, pop_err_d;

    logic [CntW-1:0] pop_req;
    logic [CntW-1:0] pop_k;
    logic [CntW-1:0] live;
    logic            pop_over;
    logic            push_acc;

    always_comb begin
        // Requests beyond the lane's drain capability are treated as MAXPOP.
        pop_req = (CntW'(pop_cnt_i) > CntW'(MAXPOP)) ? CntW'(MAXPOP) : CntW'(pop_cnt_i);
        pop_over = pop_req > cnt_q;
        pop_k    = pop_over ? cnt_q : pop_req;
        // In reset nothing moves and nothing is accepted.
        if (!rst_ni) begin
            pop_k = '0;
        end
        live       = cnt_q - pop_k;
        push_rdy_o = rst_ni && (live < CntW'(WFFOCNT));
        push_acc   = push_vld_i && push_rdy_o;
        cnt_d      = live + CntW'(push_acc);
        pop_err_d  = pop_err_q | pop_over;
        vld_d      = '0;
        for (int i = 0; i < int'(WFFOCNT); i++) begin
            vld_d[i] = CntW'(i) < cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            vld_q     <= '0;
            pop_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            vld_q     <= vld_d;
            pop_err_q <= pop_err_d;
        end
    end

    assign wrfifo_cnt_o        = cnt_q;
    assign wrfifo_vld_o        = vld_q;
    assign pop_err_o           = pop_err_q;
    assign wrfifo_vwrite_dat_o = {WFFOCNT{push_dat_i}};

    for (genvar i = 0; i < WFFOCNT; i++) begin : g_sel
        f32_wrfifo_sel_gen #(
            .CNT_W (CntW)
        ) u_sel_gen (
            .idx_i      (CntW'(i)),
            .cnt_i      (cnt_q),
            .pop_i      (pop_k),
            .push_acc_i (push_acc),
            .sel_o      (wrfifo_new_dat_sel_o[3*i +: 3]),
            .dcnt_o     (wrfifo_dcnt_o[DCNT_W*i +: DCNT_W])
        );
    end

`ifdef F32_WRFIFO_CTRL_STAT_EN
    logic [CntW-1:0] hwm_q;
    logic [15:0]     ovf_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hwm_q <= '0;
            ovf_q <= '0;
        end else begin
            if (cnt_d > hwm_q) begin
                hwm_q <= cnt_d;
            end
            if (push_vld_i && !push_rdy_o && (ovf_q != 16'hFFFF)) begin
                ovf_q <= ovf_q + 16'd1;
            end
        end
    end

    assign stat_hwm_o     = hwm_q;
    assign stat_ovf_cnt_o = ovf_q;
`endif

endmodule

// File: tb/tb_f32_wrfifo_ctrl.sv
// tb_f32_wrfifo_ctrl
// Self-checking bench for f32_wrfifo_ctrl. A queue-based FIFO model predicts
// occupancy, flags and contents; a bench-side data array applies the DUT's
// steering so contents can be compared against the queue. Directed scenarios
// pin literal values, followed by randomized traffic. Stats ports are exercised
// when F32_WRFIFO_CTRL_STAT_EN is defined.

module tb_f32_wrfifo_ctrl;
    import f32_wrfifo_pkg::*;

    localparam int W  = 256;
    localparam int N  = 16;
    localparam int CW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              push_vld;
    logic [W-1:0]      push_dat;
    logic              push_rdy;
    logic [1:0]        pop_cnt;
    logic [W*N-1:0]    vwrite;
    logic [4*N-1:0]    dcnt;
    logic [3*N-1:0]    sel;
    logic [N-1:0]      vld;
    logic [CW-1:0]     cnt;
    logic              pop_err;
`ifdef F32_WRFIFO_CTRL_STAT_EN
    logic [CW-1:0]     stat_hwm;
    logic [15:0]       stat_ovf_cnt;
`endif

    always #5 clk = ~clk;

    f32_wrfifo_ctrl #(
        .WIDTH   (W),
        .WFFOCNT (N),
        .MAXPOP  (2)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .push_vld_i           (push_vld),
        .push_dat_i           (push_dat),
        .push_rdy_o           (push_rdy),
        .pop_cnt_i            (pop_cnt),
        .wrfifo_vwrite_dat_o  (vwrite),
        .wrfifo_dcnt_o        (dcnt),
        .wrfifo_new_dat_sel_o (sel),
        .wrfifo_vld_o         (vld),
        .wrfifo_cnt_o         (cnt),
`ifdef F32_WRFIFO_CTRL_STAT_EN
        .stat_hwm_o           (stat_hwm),
        .stat_ovf_cnt_o       (stat_ovf_cnt),
`endif
        .pop_err_o            (pop_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model state
    logic [W-1:0] mq[$];
    bit           merr;
    int           mhwm;
    int           movf;

    // Bench-side data array driven by the DUT's steering outputs
    logic [W-1:0] arr[N];

    // Combinational outputs sampled in the last step, for literal pins
    logic           obs_rdy;
    logic [3*N-1:0] obs_sel;
    logic [4*N-1:0] obs_dcnt;
    logic [W*N-1:0] obs_vw;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_dat();
        logic [W-1:0] d;
        for (int j = 0; j < W / 32; j++) d[32*j +: 32] = $urandom;
        return d;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, let the
    // edge happen, apply steering to the bench array and advance the model.
    task automatic step(input bit v, input logic [W-1:0] dat, input int pop, input bit rstn);
        int           c;
        int           k;
        int           src;
        bit           e_rdy;
        bit           e_acc;
        logic [3*N-1:0] e_sel;
        logic [4*N-1:0] e_dcnt;
        logic [W-1:0] nxt[N];

        push_vld = v;
        push_dat = dat;
        pop_cnt  = 2'(pop);
        rst_n    = rstn;
        #2;

        c = mq.size();
        chk("cnt", W'(cnt), W'(c));
        chk("vld", W'(vld), W'((32'd1 << c) - 1));
        chk("pop_err", W'(pop_err), W'(merr));
`ifdef F32_WRFIFO_CTRL_STAT_EN
        chk("stat_hwm", W'(stat_hwm), W'(mhwm));
        chk("stat_ovf", W'(stat_ovf_cnt), W'(movf));
`endif

        k     = rstn ? ((pop < c) ? pop : c) : 0;
        e_rdy = rstn && ((c - k) < N);
        e_acc = v && e_rdy;
        for (int i = 0; i < N; i++) begin
            // Survivor at i+k moves to i; the new item goes right after survivors.
            if (k > 0 && (i + k) < c) begin
                e_sel[3*i +: 3]  = SEL_SHIFT;
                e_dcnt[4*i +: 4] = 4'(k);
            end else if (e_acc && i == (c - k)) begin
                e_sel[3*i +: 3]  = SEL_LOAD;
                e_dcnt[4*i +: 4] = 4'd0;
            end else begin
                e_sel[3*i +: 3]  = SEL_HOLD;
                e_dcnt[4*i +: 4] = 4'd0;
            end
        end

        obs_rdy  = push_rdy;
        obs_sel  = sel;
        obs_dcnt = dcnt;
        obs_vw   = vwrite;
        chk("push_rdy", W'(obs_rdy), W'(e_rdy));
        chk("sel", W'(obs_sel), W'(e_sel));
        chk("dcnt", W'(obs_dcnt), W'(e_dcnt));
        if (e_acc) begin
            for (int i = 0; i < N; i++) chk("vwrite", obs_vw[W*i +: W], dat);
        end

        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            case (obs_sel[3*i +: 3])
                SEL_LOAD:  nxt[i] = obs_vw[W*i +: W];
                SEL_SHIFT: begin
                    src    = i + int'(obs_dcnt[4*i +: 4]);
                    nxt[i] = (src < N) ? arr[src] : 'x;
                end
                default:   nxt[i] = arr[i];
            endcase
        end
        arr = nxt;

        if (!rstn) begin
            mq.delete();
            merr = 1'b0;
            mhwm = 0;
            movf = 0;
        end else begin
            if (pop > c) merr = 1'b1;
            if (v && !e_rdy && movf < 65535) movf++;
            for (int i = 0; i < k; i++) void'(mq.pop_front());
            if (e_acc) mq.push_back(dat);
            if (mq.size() > mhwm) mhwm = mq.size();
        end
        #1;
        for (int i = 0; i < mq.size(); i++) chk("entry", arr[i], mq[i]);
    endtask

    initial begin
        int ppush;
        logic [W-1:0] d;

        merr = 1'b0;
        mhwm = 0;
        movf = 0;
        for (int i = 0; i < N; i++) arr[i] = '0;
        rst_n    = 1'b0;
        push_vld = 1'b0;
        push_dat = '0;
        pop_cnt  = 2'd0;
        @(posedge clk);
        #1;
        step(1'b0, '0, 0, 1'b0);

`ifdef F32_WRFIFO_CTRL_STAT_EN
        for (int i = 0; i < 20; i++) step(1'b1, rnd_dat(), 0, 1'b1);
        chk("stat_hwm_20", W'(stat_hwm), W'(16));
        chk("stat_ovf_20", W'(stat_ovf_cnt), W'(4));
        step(1'b0, '0, 0, 1'b0);
`endif

        // Three consecutive pushes, no pops
        step(1'b1, W'(8'hA1), 0, 1'b1);
        chk("a1_sel0", W'(obs_sel[2:0]), W'(3'b001));
        step(1'b1, W'(8'hA2), 0, 1'b1);
        chk("a2_sel1", W'(obs_sel[5:3]), W'(3'b001));
        step(1'b1, W'(8'hA3), 0, 1'b1);
        chk("a3_sel2", W'(obs_sel[8:6]), W'(3'b001));
        chk("a_cnt", W'(cnt), W'(3));
        chk("a_e0", arr[0], W'(8'hA1));
        chk("a_e1", arr[1], W'(8'hA2));
        chk("a_e2", arr[2], W'(8'hA3));

        // Pop two with simultaneous push
        step(1'b1, W'(8'hB0), 2, 1'b1);
        chk("b_sel0", W'(obs_sel[2:0]), W'(3'b010));
        chk("b_dcnt0", W'(obs_dcnt[3:0]), W'(4'd2));
        chk("b_sel1", W'(obs_sel[5:3]), W'(3'b001));
        chk("b_cnt", W'(cnt), W'(2));
        chk("b_e0", arr[0], W'(8'hA3));
        chk("b_e1", arr[1], W'(8'hB0));

        // Fill to 16, then push into a full FIFO
        for (int i = 0; i < 14; i++) step(1'b1, rnd_dat(), 0, 1'b1);
        step(1'b1, W'(8'hC0), 0, 1'b1);
        chk("full_rdy0", W'(obs_rdy), W'(0));
        chk("full_hold", W'(obs_sel), W'(48'h924924924924));
        chk("full_cnt", W'(cnt), W'(16));
        step(1'b1, W'(8'hC1), 1, 1'b1);
        chk("full_rdy1", W'(obs_rdy), W'(1));
        chk("full_sel", W'(obs_sel), W'(48'h292492492492));
        chk("full_dcnt", W'(obs_dcnt), W'(64'h0111111111111111));
        chk("full_e15", arr[15], W'(8'hC1));

        // Drain to one, then over-pop
        for (int i = 0; i < 7; i++) step(1'b0, '0, 2, 1'b1);
        step(1'b0, '0, 1, 1'b1);
        step(1'b0, '0, 2, 1'b1);
        chk("err_hold", W'(obs_sel), W'(48'h924924924924));
        chk("err_set", W'(pop_err), W'(1));
        chk("err_cnt", W'(cnt), W'(0));
        step(1'b0, '0, 0, 1'b1);
        chk("err_sticky", W'(pop_err), W'(1));

        // Pop on empty with a push: lands in entry 0
        step(1'b1, W'(8'hD0), 2, 1'b1);
        chk("empty_e0", arr[0], W'(8'hD0));
        chk("empty_cnt", W'(cnt), W'(1));

        // Reset mid-operation at occupancy 7
        for (int i = 0; i < 6; i++) step(1'b1, rnd_dat(), 0, 1'b1);
        chk("pre_rst_cnt", W'(cnt), W'(7));
        step(1'b1, rnd_dat(), 1, 1'b0);
        chk("rst_rdy", W'(obs_rdy), W'(0));
        chk("rst_hold", W'(obs_sel), W'(48'h924924924924));
        chk("rst_dcnt", W'(obs_dcnt), W'(0));
        chk("rst_cnt", W'(cnt), W'(0));
        chk("rst_vld", W'(vld), W'(0));
        chk("rst_err", W'(pop_err), W'(0));

        // Randomized traffic with alternating fill/drain bias
        for (int blk = 0; blk < 6; blk++) begin
            ppush = (blk % 2 == 0) ? 85 : 30;
            for (int i = 0; i < 100; i++) begin
                d = rnd_dat();
                step(($urandom_range(99) < ppush), d, int'($urandom_range(2)),
                     ($urandom_range(63) != 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
